// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-port unified instruction/data memory between the CPU
//   memory interface (c_*) and the DMA/boot-loader port (d_*), one transaction
//   at a time. Each transaction is IDLE -> ACCESS -> WAIT (MEM_LAT cycles) ->
//   RESP. In RESP the owner gets a one-cycle ack with registered read data.
//
//   Build option: define ARB_ROUND_ROBIN_EN to alternate grants on a tie
//   (the first tie after reset goes to the CPU). When it is undefined, the CPU
//   always wins a tie.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   c_req/c_we/c_addr/c_wdata       CPU request, held stable until c_ack
//   c_ack, c_rdata                  CPU completion pulse and read data
//   d_req/d_we/d_addr/d_wdata       DMA request, same rules as CPU
//   d_ack, d_rdata                  DMA completion pulse and read data
//   m_en/m_we/m_addr/m_wdata        memory strobe, write enable, address, data
//   m_rdata                         memory read data, valid MEM_LAT cycles after m_en
//   busy                            arbiter not idle
//   gnt_id                          owner of current transaction (0=CPU, 1=DMA)
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ack,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          busy,
    output logic          gnt_id
);

    localparam int unsigned LCW = 4;

    // Latency counter is 4 bits wide, so only 1..15 can be represented.
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_range
        $error("mem_port_arbiter: MEM_LAT must be within 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         state;
    logic [LCW-1:0] lat_cnt;
    logic           win_dma;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_gnt;

    // On a tie the port that was not granted last wins; a lone requester always wins.
    assign win_dma = d_req & (~c_req | ~last_gnt);

    // Remember the owner of each transaction as it enters ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
        end else if (state == S_IDLE && (c_req || d_req)) begin
            last_gnt <= win_dma;
        end
    end
`else
    // Fixed priority: the CPU wins any tie.
    assign win_dma = d_req & ~c_req;
`endif

    // Transaction sequencer. The m_* registers hold the latched request for the
    // single ACCESS cycle only and are zero otherwise; ack/rdata are one-cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            lat_cnt <= '0;
            gnt_id  <= 1'b0;
            busy    <= 1'b0;
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            c_ack   <= 1'b0;
            d_ack   <= 1'b0;
            c_rdata <= '0;
            d_rdata <= '0;
        end else begin
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            c_ack   <= 1'b0;
            d_ack   <= 1'b0;
            c_rdata <= '0;
            d_rdata <= '0;

            case (state)
                S_IDLE: begin
                    if (c_req || d_req) begin
                        state   <= S_ACCESS;
                        busy    <= 1'b1;
                        gnt_id  <= win_dma;
                        lat_cnt <= LCW'(MEM_LAT);
                        m_en    <= 1'b1;
                        m_we    <= win_dma ? d_we    : c_we;
                        m_addr  <= win_dma ? d_addr  : c_addr;
                        m_wdata <= win_dma ? d_wdata : c_wdata;
                    end
                end

                S_ACCESS: begin
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    lat_cnt <= lat_cnt - LCW'(1);
                    // The owner's rdata register doubles as the captured read data.
                    if (lat_cnt == LCW'(1)) begin
                        state <= S_RESP;
                        c_ack <= ~gnt_id;
                        d_ack <= gnt_id;
                        if (gnt_id) begin
                            d_rdata <= m_rdata;
                        end else begin
                            c_rdata <= m_rdata;
                        end
                    end
                end

                S_RESP: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: two instances (MEM_LAT=1 on slot 0,
// MEM_LAT=3 on slot 1) with a small memory model that presents read data only
// in the exact cycle it is due, and junk otherwise.
module tb_mem_port_arbiter;

    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0]       c_req, c_we, d_req, d_we;
    logic [1:0][31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic [1:0]       c_ack, d_ack, m_en, m_we, busy, gnt_id;
    logic [1:0][31:0] c_rdata, d_rdata, m_addr, m_wdata, m_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req[0]), .c_we(c_we[0]), .c_addr(c_addr[0]), .c_wdata(c_wdata[0]),
        .c_ack(c_ack[0]), .c_rdata(c_rdata[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_ack(d_ack[0]), .d_rdata(d_rdata[0]),
        .m_en(m_en[0]), .m_we(m_we[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]),
        .m_rdata(m_rdata[0]), .busy(busy[0]), .gnt_id(gnt_id[0])
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req[1]), .c_we(c_we[1]), .c_addr(c_addr[1]), .c_wdata(c_wdata[1]),
        .c_ack(c_ack[1]), .c_rdata(c_rdata[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_ack(d_ack[1]), .d_rdata(d_rdata[1]),
        .m_en(m_en[1]), .m_we(m_we[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]),
        .m_rdata(m_rdata[1]), .busy(busy[1]), .gnt_id(gnt_id[1])
    );

    // ---------------- memory model ----------------
    logic [1:0]       pend, wr_valid;
    logic [1:0][3:0]  left;
    logic [1:0][31:0] pend_addr, wr_addr, wr_data;
    logic [1:0][15:0] men_cnt;

    function automatic int lat_of(input int p);
        return (p == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a, input logic wv,
                                             input logic [31:0] wa, input logic [31:0] wd);
        if (wv && a == wa) return wd;
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return 32'hA000_0000 | a;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= '0;
            left      <= '0;
            pend_addr <= '0;
            wr_valid  <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            men_cnt   <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (pend[p]) begin
                    if (left[p] == 4'd0) pend[p] <= 1'b0;
                    else                 left[p] <= left[p] - 4'd1;
                end
                if (m_en[p]) begin
                    men_cnt[p]   <= men_cnt[p] + 16'd1;
                    pend[p]      <= 1'b1;
                    left[p]      <= 4'(lat_of(p) - 1);
                    pend_addr[p] <= m_addr[p];
                    if (m_we[p]) begin
                        wr_valid[p] <= 1'b1;
                        wr_addr[p]  <= m_addr[p];
                        wr_data[p]  <= m_wdata[p];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            m_rdata[p] = (pend[p] && left[p] == 4'd0) ?
                         mem_read(pend_addr[p], wr_valid[p], wr_addr[p], wr_data[p]) : JUNK;
        end
    end

    // ---------------- helpers ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        c_req = '0; c_we = '0; d_req = '0; d_we = '0;
        c_addr = '0; c_wdata = '0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    // One transaction from a single requester; called at cycle 0 with the DUT idle.
    task automatic single_txn(input int p, input bit dma, input bit we,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rd_exp, input string tag);
        int lat;
        logic own_ack, oth_ack;
        logic [31:0] own_rd;
        logic [15:0] cnt0;
        lat  = lat_of(p);
        cnt0 = men_cnt[p];
        if (dma) begin
            d_we[p] = we; d_addr[p] = addr; d_wdata[p] = wdata; d_req[p] = 1'b1;
        end else begin
            c_we[p] = we; c_addr[p] = addr; c_wdata[p] = wdata; c_req[p] = 1'b1;
        end
        for (int k = 0; k <= lat + 2; k++) begin
            @(negedge clk);
            own_ack = dma ? d_ack[p] : c_ack[p];
            oth_ack = dma ? c_ack[p] : d_ack[p];
            own_rd  = dma ? d_rdata[p] : c_rdata[p];
            check_eq($sformatf("%s m_en c%0d", tag, k), 32'(m_en[p]), 32'(k == 1));
            check_eq($sformatf("%s busy c%0d", tag, k), 32'(busy[p]), 32'(k >= 1));
            check_eq($sformatf("%s ack c%0d", tag, k), 32'(own_ack), 32'(k == lat + 2));
            check_eq($sformatf("%s other_ack c%0d", tag, k), 32'(oth_ack), 32'd0);
            if (k == 1) begin
                check_eq($sformatf("%s m_addr", tag), m_addr[p], addr);
                check_eq($sformatf("%s m_we", tag), 32'(m_we[p]), 32'(we));
                check_eq($sformatf("%s m_wdata", tag), m_wdata[p], wdata);
                check_eq($sformatf("%s gnt_id", tag), 32'(gnt_id[p]), 32'(dma));
            end else begin
                check_eq($sformatf("%s m_addr idle c%0d", tag, k), m_addr[p], 32'd0);
            end
            if (k == lat + 2) begin
                if (!we) check_eq($sformatf("%s rdata", tag), own_rd, rd_exp);
            end else begin
                check_eq($sformatf("%s rdata zero c%0d", tag, k), own_rd, 32'd0);
            end
            next_cycle();
        end
        if (dma) d_req[p] = 1'b0;
        else     c_req[p] = 1'b0;
        @(negedge clk);
        check_eq($sformatf("%s busy after", tag), 32'(busy[p]), 32'd0);
        check_eq($sformatf("%s m_en count", tag), 32'(men_cnt[p] - cnt0), 32'd1);
        next_cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit rr;
        logic [15:0] cnt0;
        int owner;
`ifdef ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif

        // Reset values on both instances
        clear_inputs();
        rst_n = 1'b0;
        #2;
        for (int p = 0; p < 2; p++) begin
            check_eq($sformatf("rst m_en %0d", p), 32'(m_en[p]), 32'd0);
            check_eq($sformatf("rst m_we %0d", p), 32'(m_we[p]), 32'd0);
            check_eq($sformatf("rst busy %0d", p), 32'(busy[p]), 32'd0);
            check_eq($sformatf("rst gnt_id %0d", p), 32'(gnt_id[p]), 32'd0);
            check_eq($sformatf("rst c_ack %0d", p), 32'(c_ack[p]), 32'd0);
            check_eq($sformatf("rst d_ack %0d", p), 32'(d_ack[p]), 32'd0);
            check_eq($sformatf("rst m_addr %0d", p), m_addr[p], 32'd0);
            check_eq($sformatf("rst m_wdata %0d", p), m_wdata[p], 32'd0);
            check_eq($sformatf("rst c_rdata %0d", p), c_rdata[p], 32'd0);
            check_eq($sformatf("rst d_rdata %0d", p), d_rdata[p], 32'd0);
        end
        do_reset();

        // Basic transactions
        single_txn(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, "lat1_cpu_rd");
        single_txn(1, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 32'h0, "lat3_dma_wr");
        check_eq("lat3_dma_wr mem addr", wr_addr[1], 32'h20);
        check_eq("lat3_dma_wr mem data", wr_data[1], 32'h1234_5678);
        single_txn(1, 1'b0, 1'b0, 32'h20, 32'h0, 32'h1234_5678, "lat3_cpu_rd_back");
        single_txn(0, 1'b1, 1'b0, 32'h44, 32'h0, 32'hA000_0044, "lat1_dma_rd");

        // Simultaneous requests after reset: CPU first, DMA in the next slot
        do_reset();
        c_addr[0] = 32'h10; c_req[0] = 1'b1;
        d_addr[0] = 32'h30; d_req[0] = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            check_eq($sformatf("tie m_en c%0d", k), 32'(m_en[0]), 32'(k == 1 || k == 5));
            check_eq($sformatf("tie busy c%0d", k), 32'(busy[0]),
                     32'((k >= 1 && k <= 3) || (k >= 5 && k <= 7)));
            check_eq($sformatf("tie c_ack c%0d", k), 32'(c_ack[0]), 32'(k == 3));
            check_eq($sformatf("tie d_ack c%0d", k), 32'(d_ack[0]), 32'(k == 7));
            if (k == 1) begin
                check_eq("tie gnt cpu", 32'(gnt_id[0]), 32'd0);
                check_eq("tie addr cpu", m_addr[0], 32'h10);
            end
            if (k == 5) begin
                check_eq("tie gnt dma", 32'(gnt_id[0]), 32'd1);
                check_eq("tie addr dma", m_addr[0], 32'h30);
            end
            if (k == 3) check_eq("tie c_rdata", c_rdata[0], 32'hDEAD_BEEF);
            if (k == 7) check_eq("tie d_rdata", d_rdata[0], 32'hA000_0030);
            next_cycle();
            if (k == 3) c_req[0] = 1'b0;
            if (k == 7) d_req[0] = 1'b0;
        end

        // Both requesting continuously for four transactions
        do_reset();
        c_addr[0] = 32'h10; c_req[0] = 1'b1;
        d_addr[0] = 32'h40; d_req[0] = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            owner = rr ? ((k / 4) % 2) : 0;
            check_eq($sformatf("cont m_en c%0d", k), 32'(m_en[0]), 32'(k % 4 == 1 && k < 16));
            if (k % 4 == 1 && k < 16) begin
                check_eq($sformatf("cont gnt c%0d", k), 32'(gnt_id[0]), 32'(owner));
                check_eq($sformatf("cont addr c%0d", k), m_addr[0],
                         (owner == 1) ? 32'h40 : 32'h10);
            end
            if (k % 4 == 3) begin
                check_eq($sformatf("cont c_ack c%0d", k), 32'(c_ack[0]), 32'(owner == 0));
                check_eq($sformatf("cont d_ack c%0d", k), 32'(d_ack[0]), 32'(owner == 1));
            end else begin
                check_eq($sformatf("cont acks c%0d", k), 32'({c_ack[0], d_ack[0]}), 32'd0);
            end
            next_cycle();
            if (k == 15) begin
                c_req[0] = 1'b0;
                d_req[0] = 1'b0;
            end
        end

        // Back-to-back CPU reads with c_req held across the first ack
        do_reset();
        cnt0 = men_cnt[0];
        c_addr[0] = 32'h10; c_req[0] = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            check_eq($sformatf("b2b m_en c%0d", k), 32'(m_en[0]), 32'(k == 1 || k == 5));
            check_eq($sformatf("b2b c_ack c%0d", k), 32'(c_ack[0]), 32'(k == 3 || k == 7));
            if (k == 3 || k == 7) check_eq($sformatf("b2b c_rdata c%0d", k), c_rdata[0], 32'hDEAD_BEEF);
            next_cycle();
            if (k == 7) c_req[0] = 1'b0;
        end
        check_eq("b2b m_en count", 32'(men_cnt[0] - cnt0), 32'd2);

        // Asynchronous reset during ACCESS (lat1 instance)
        c_addr[0] = 32'h10; c_req[0] = 1'b1;
        next_cycle();
        @(negedge clk);
        check_eq("rst_access m_en before", 32'(m_en[0]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_access m_en", 32'(m_en[0]), 32'd0);
        check_eq("rst_access busy", 32'(busy[0]), 32'd0);
        check_eq("rst_access m_addr", m_addr[0], 32'd0);
        do_reset();

        // Asynchronous reset during WAIT (lat3 instance), then full recovery
        c_addr[1] = 32'h10; c_req[1] = 1'b1;
        repeat (3) next_cycle();
        @(negedge clk);
        check_eq("rst_wait busy before", 32'(busy[1]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_wait busy", 32'(busy[1]), 32'd0);
        check_eq("rst_wait m_en", 32'(m_en[1]), 32'd0);
        check_eq("rst_wait c_ack", 32'(c_ack[1]), 32'd0);
        c_req[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq($sformatf("rst_wait no ack %0d", k), 32'(c_ack[1]), 32'd0);
        end
        rst_n = 1'b1;
        next_cycle();
        single_txn(1, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, "lat3_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
